data_dewhiting: RTL

//  Receive-side inverse of the transmit data whitener. Sits after the deframer, which strips the
//  80-bit padding preamble and delivers whitened payload bytes. Regenerates the same 9-bit

---
 rtl/data_dewhiting.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_dewhiting.sv
// Receive-side de-whitener: regenerates the transmit LFSR (x^9+x^5+1) per payload
// byte, XORs it onto incoming bytes, counts payload bytes and flags overruns.
module data_dewhiting #(
    parameter logic [8:0]  SEED      = 9'h001,
    parameter int unsigned MAX_BYTES = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             frame_start,
    input  logic             frame_end,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             overflow,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);

    // Eight single-bit LFSR steps: the transmitter advances once per bit.
    function automatic logic [8:0] adv8(input logic [8:0] s);
        logic [8:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[5] ^ t[0], t[8:1]};
        end
        return t;
    endfunction

    state_t           state_q, state_d;
    logic [8:0]       lfsr_q, lfsr_d;
    logic [8:0]       lfsr_base, lfsr_adv;
    logic [CNT_W-1:0] cnt_base, cnt_d;
    logic [7:0]       dout_d;
    logic             take_byte;
    logic             done_d, abort_d, ovf_d;

    // Next state, LFSR/counter update and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        lfsr_base = lfsr_q;
        cnt_base  = byte_count;
        take_byte = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        ovf_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    // A same-cycle frame_end closes the frame immediately.
                    lfsr_base = SEED;
                    cnt_base  = '0;
                    take_byte = din_valid;
                    done_d    = frame_end;
                    state_d   = frame_end ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (frame_start) begin
                    // Restart wins over a same-cycle frame_end; the byte opens the new frame.
                    abort_d   = 1'b1;
                    lfsr_base = SEED;
                    cnt_base  = '0;
                    take_byte = din_valid;
                end else begin
                    if (din_valid) begin
                        if (cnt_base < CNT_MAX) begin
                            take_byte = 1'b1;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end
                    if (frame_end) begin
                        done_d  = !ovf_d;
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (frame_start) begin
                    lfsr_base = SEED;
                    cnt_base  = '0;
                    take_byte = din_valid;
                    state_d   = PAYLOAD;
                end else if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        lfsr_adv = adv8(lfsr_base);
        lfsr_d   = take_byte ? lfsr_adv : lfsr_base;
        cnt_d    = take_byte ? cnt_base + CNT_W'(1) : cnt_base;
        dout_d   = take_byte ? (din ^ lfsr_adv[7:0]) : dout;
    end

    // State, LFSR and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            dout        <= '0;
            dout_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            overflow    <= 1'b0;
            byte_count  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            dout        <= dout_d;
            dout_valid  <= take_byte;
            frame_done  <= done_d;
            frame_abort <= abort_d;
            overflow    <= ovf_d;
            byte_count  <= cnt_d;
        end
    end

endmodule
